// File: rtl/ad9915_pkg.sv
// Shared constants and types for the AD9915 serial-port responder.
package ad9915_pkg;

   localparam int TRANSACTION_LENGTH = 40;
   localparam int INSTR_BITS         = 8;

   localparam logic [6:0] CFR1      = 7'h00;
   localparam logic [6:0] CFR2      = 7'h01;
   localparam logic [6:0] CFR3      = 7'h02;
   localparam logic [6:0] CFR4      = 7'h03;
   localparam logic [6:0] RAMP_LO   = 7'h04;
   localparam logic [6:0] RAMP_HI   = 7'h05;
   localparam logic [6:0] STEP_UP   = 7'h06;
   localparam logic [6:0] STEP_DN   = 7'h07;
   localparam logic [6:0] RAMP_RATE = 7'h08;

   typedef enum logic [1:0] {
      ST_INSTR   = 2'd0,
      ST_DATA_WR = 2'd1,
      ST_DATA_RD = 2'd2
   } resp_state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detection
// on the synchronised level.
module edge_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic srst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // synchroniser chain plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
      end else if (srst) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = sync_r[SYNC_STAGES-1] & ~prev_r;
   assign fall  = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/ad9915_spi_responder.sv
// DDS serial-port emulator: decodes 40-bit instruction+data frames into a shadow
// register bank, commits shadow to active on IO_Update, and serves reads on SDO.
module ad9915_spi_responder
   import ad9915_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        srst,
   input  logic        sclk,
   input  logic        ncs,
   input  logic        sdio,
   input  logic        sync_io,
   input  logic        io_update,
   output logic        sdo,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        wr_valid,
   output logic [6:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        update,
   output logic        error
);

   localparam int         ADDR_W     = $clog2(NUM_REGS);
   localparam logic [5:0] INSTR_LAST = 6'(INSTR_BITS - 1);
   localparam logic [5:0] XFER_LAST  = 6'(TRANSACTION_LENGTH - 1);

   function automatic logic in_range(input logic [6:0] a);
      return {25'd0, a} < 32'(NUM_REGS);
   endfunction

   logic sclk_lvl_s, sclk_rise_s, sclk_fall_s, ncs_lvl_s, ncs_rise_s, ncs_fall_s;
   logic sync_lvl_s, sync_rise_s, sync_fall_s, upd_lvl_s, upd_rise_s, upd_fall_s;
   logic unused_s;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .srst(srst),
      .din(sclk), .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
   edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (.clk(clk), .rst_n(rst_n), .srst(srst),
      .din(ncs), .level(ncs_lvl_s), .rise(ncs_rise_s), .fall(ncs_fall_s));
   edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (.clk(clk), .rst_n(rst_n), .srst(srst),
      .din(sync_io), .level(sync_lvl_s), .rise(sync_rise_s), .fall(sync_fall_s));
   edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_upd (.clk(clk), .rst_n(rst_n), .srst(srst),
      .din(io_update), .level(upd_lvl_s), .rise(upd_rise_s), .fall(upd_fall_s));

   assign unused_s = ^{sclk_lvl_s, ncs_fall_s, sync_rise_s, sync_fall_s, upd_lvl_s, upd_fall_s};

   resp_state_e            state_r, state_n;
   logic [5:0]             cnt_r, cnt_n;
   logic [SYNC_STAGES-1:0] sdio_sync_r;
   logic [6:0]             addr_r;
   logic [31:0]            data_r, shift_r, rd_data_r, wr_data_r;
   logic [6:0]             wr_addr_r;
   logic                   commit_r, sdo_r, wr_valid_r, update_r, error_r;
   logic [31:0]            shadow_r [NUM_REGS];
   logic [31:0]            active_r [NUM_REGS];

   logic        rise_s, fall_s, abort_s, sdio_s, commit_ok_s;
   logic [7:0]  instr_next_s;
   logic [31:0] rd_word_s;
   logic        load_instr_s, shift_in_s, enter_rd_s, done_wr_s, shift_out_s;

   // SClk edges only count while the port is selected and not being resynced
   assign rise_s       = sclk_rise_s & ~ncs_lvl_s & ~sync_lvl_s;
   assign fall_s       = sclk_fall_s & ~ncs_lvl_s & ~sync_lvl_s;
   assign abort_s      = (sync_lvl_s | ncs_rise_s) & (cnt_r != 6'd0);
   assign sdio_s       = sdio_sync_r[SYNC_STAGES-1];
   assign instr_next_s = {addr_r, sdio_s};
   assign commit_ok_s  = commit_r & in_range(addr_r);
   assign rd_word_s    = in_range(instr_next_s[6:0]) ? active_r[instr_next_s[ADDR_W-1:0]] : 32'd0;

   // state and bit-counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_INSTR;
         cnt_r   <= 6'd0;
      end else if (srst) begin
         state_r <= ST_INSTR;
         cnt_r   <= 6'd0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
      end
   end

   // next state; a read holds the counter at 7 so the fall right after the
   // instruction is skipped and the 32 data falls end on the 40th clock
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      if (abort_s) begin
         state_n = ST_INSTR;
         cnt_n   = 6'd0;
      end else begin
         case (state_r)
            ST_INSTR: begin
               if (rise_s && cnt_r == INSTR_LAST) begin
                  state_n = instr_next_s[7] ? ST_DATA_RD : ST_DATA_WR;
                  cnt_n   = instr_next_s[7] ? cnt_r : cnt_r + 6'd1;
               end else if (rise_s) begin
                  cnt_n = cnt_r + 6'd1;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            ST_DATA_WR: begin
               if (rise_s && cnt_r == XFER_LAST) begin
                  state_n = ST_INSTR;
                  cnt_n   = 6'd0;
               end else if (rise_s) begin
                  cnt_n = cnt_r + 6'd1;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            ST_DATA_RD: begin
               if (fall_s && cnt_r == XFER_LAST) begin
                  state_n = ST_INSTR;
                  cnt_n   = 6'd0;
               end else if (fall_s) begin
                  cnt_n = cnt_r + 6'd1;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            default: begin
               state_n = ST_INSTR;
               cnt_n   = 6'd0;
            end
         endcase
      end
   end

   // datapath controls decoded from state; an abort suppresses all of them
   always_comb begin
      load_instr_s = 1'b0;
      shift_in_s   = 1'b0;
      enter_rd_s   = 1'b0;
      done_wr_s    = 1'b0;
      shift_out_s  = 1'b0;
      if (abort_s) begin
         load_instr_s = 1'b0;
      end else begin
         case (state_r)
            ST_INSTR: begin
               load_instr_s = rise_s;
               enter_rd_s   = rise_s & (cnt_r == INSTR_LAST) & instr_next_s[7];
            end
            ST_DATA_WR: begin
               shift_in_s = rise_s;
               done_wr_s  = rise_s & (cnt_r == XFER_LAST);
            end
            ST_DATA_RD: shift_out_s = fall_s & (cnt_r != INSTR_LAST);
            default:    load_instr_s = 1'b0;
         endcase
      end
   end

   // serial shifters and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdio_sync_r <= '0;
         addr_r      <= 7'd0;
         data_r      <= 32'd0;
         shift_r     <= 32'd0;
         sdo_r       <= 1'b0;
         commit_r    <= 1'b0;
         wr_valid_r  <= 1'b0;
         wr_addr_r   <= 7'd0;
         wr_data_r   <= 32'd0;
         update_r    <= 1'b0;
         error_r     <= 1'b0;
      end else if (srst) begin
         sdio_sync_r <= '0;
         addr_r      <= 7'd0;
         data_r      <= 32'd0;
         shift_r     <= 32'd0;
         sdo_r       <= 1'b0;
         commit_r    <= 1'b0;
         wr_valid_r  <= 1'b0;
         wr_addr_r   <= 7'd0;
         wr_data_r   <= 32'd0;
         update_r    <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         sdio_sync_r <= {sdio_sync_r[SYNC_STAGES-2:0], sdio};
         commit_r    <= done_wr_s;
         if (load_instr_s) addr_r <= instr_next_s[6:0];
         if (shift_in_s)   data_r <= {data_r[30:0], sdio_s};
         if (enter_rd_s) begin
            shift_r <= rd_word_s;
            sdo_r   <= rd_word_s[31];
         end else if (shift_out_s) begin
            shift_r <= shift_r << 1;
            sdo_r   <= shift_r[30];
         end
         wr_valid_r <= commit_ok_s;
         if (commit_ok_s) begin
            wr_addr_r <= addr_r;
            wr_data_r <= data_r;
         end
         update_r <= upd_rise_s;
         error_r  <= abort_s | (commit_r & ~in_range(addr_r))
                   | (enter_rd_s & ~in_range(instr_next_s[6:0]));
      end
   end

   // register banks; a write committing with IO_Update is forwarded into the copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_r[i] <= 32'd0;
            active_r[i] <= 32'd0;
         end
         rd_data_r <= 32'd0;
      end else if (srst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_r[i] <= 32'd0;
            active_r[i] <= 32'd0;
         end
         rd_data_r <= 32'd0;
      end else begin
         if (commit_ok_s) shadow_r[addr_r[ADDR_W-1:0]] <= data_r;
         if (upd_rise_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (commit_ok_s && addr_r[ADDR_W-1:0] == ADDR_W'(i)) active_r[i] <= data_r;
               else                                                active_r[i] <= shadow_r[i];
            end
         end
         rd_data_r <= in_range({3'b000, rd_addr}) ? active_r[rd_addr[ADDR_W-1:0]] : 32'd0;
      end
   end

   assign sdo      = sdo_r;
   assign rd_data  = rd_data_r;
   assign wr_valid = wr_valid_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;
   assign update   = update_r;
   assign error    = error_r;

endmodule

// File: tb/tb_ad9915_spi_responder.sv
// Directed bench for the AD9915 serial-port responder: drives 40-bit frames on
// a slow SClk and checks strobes, register banks and SDO read-back.
module tb_ad9915_spi_responder;
   import ad9915_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, srst, sclk, ncs, sdio, sync_io, io_update;
   logic        sdo, wr_valid, update, error;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data, wr_data;
   logic [6:0]  wr_addr;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0, err_cnt = 0, upd_cnt = 0;
   logic [6:0]  last_wr_addr = 7'd0;
   logic [31:0] last_wr_data = 32'd0;

   always #5 clk = ~clk;

   ad9915_spi_responder dut (
      .clk(clk), .rst_n(rst_n), .srst(srst), .sclk(sclk), .ncs(ncs), .sdio(sdio),
      .sync_io(sync_io), .io_update(io_update), .sdo(sdo), .rd_addr(rd_addr),
      .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .update(update), .error(error)
   );

   // strobe monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
      end
      if (error)  err_cnt++;
      if (update) upd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bit(input logic b, input logic upd_after_rise, output logic s);
      sdio = b;
      repeat (4) @(negedge clk);
      s    = sdo;
      sclk = 1'b1;
      @(negedge clk);
      if (upd_after_rise) io_update = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] instr, input logic [31:0] data, input int nbits,
                       input logic upd_last, output logic [39:0] cap);
      logic [39:0] word;
      logic        s;
      word = {instr, data};
      cap  = 40'd0;
      ncs  = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(word[39-i], upd_last && (i == 39), s);
         cap = {cap[38:0], s};
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_release();
      ncs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic full_write(input logic [6:0] a, input logic [31:0] d);
      logic [39:0] cap;
      xfer({1'b0, a}, d, 40, 1'b0, cap);
      cs_release();
   endtask

   task automatic pulse_update();
      io_update = 1'b1;
      repeat (4) @(negedge clk);
      io_update = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic rd_reg(input logic [6:0] a, output logic [31:0] v);
      rd_addr = a[3:0];
      repeat (2) @(negedge clk);
      v = rd_data;
   endtask

   initial begin
      logic [31:0] v;
      logic [39:0] cap;
      int w0, e0, u0;

      rst_n = 1'b0; srst = 1'b0; sclk = 1'b0; ncs = 1'b1; sdio = 1'b0;
      sync_io = 1'b0; io_update = 1'b0; rd_addr = 4'd0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // reset state
      chk("reset_strobes", {28'd0, sdo, wr_valid, update, error}, 32'd0);
      chk("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
      chk("reset_wr_data", wr_data, 32'd0);
      rd_reg(CFR1, v);      chk("reset_cfr1", v, 32'd0);
      rd_reg(CFR3, v);      chk("reset_cfr3", v, 32'd0);
      rd_reg(RAMP_RATE, v); chk("reset_ramp_rate", v, 32'd0);

      // 1: write then commit
      w0 = wr_cnt; u0 = upd_cnt;
      full_write(RAMP_LO, 32'h12345678);
      chk("t1_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("t1_wr_addr", {25'd0, last_wr_addr}, 32'h4);
      chk("t1_wr_data", last_wr_data, 32'h12345678);
      rd_reg(RAMP_LO, v);   chk("t1_active_before_upd", v, 32'd0);
      pulse_update();
      chk("t1_upd_count", 32'(upd_cnt - u0), 32'd1);
      rd_reg(RAMP_LO, v);   chk("t1_active_after_upd", v, 32'h12345678);

      // 2: abort after 20 bits via SyncIO
      w0 = wr_cnt; e0 = err_cnt;
      xfer({1'b0, RAMP_HI}, 32'hFFFFFFFF, 20, 1'b0, cap);
      sync_io = 1'b1;
      repeat (6) @(negedge clk);
      sync_io = 1'b0;
      repeat (4) @(negedge clk);
      cs_release();
      chk("t2_abort_err", 32'(err_cnt - e0), 32'd1);
      chk("t2_abort_no_wr", 32'(wr_cnt - w0), 32'd0);
      pulse_update();
      rd_reg(RAMP_HI, v);   chk("t2_ramp_hi_untouched", v, 32'd0);
      rd_reg(RAMP_LO, v);   chk("t2_ramp_lo_kept", v, 32'h12345678);
      w0 = wr_cnt;
      full_write(RAMP_HI, 32'hCAFEF00D);
      chk("t2_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("t2_wr_addr", {25'd0, last_wr_addr}, 32'h5);
      chk("t2_wr_data", last_wr_data, 32'hCAFEF00D);
      chk("t2_no_new_err", 32'(err_cnt - e0), 32'd1);

      // 3: read back RAMP_LO on SDO, then an out-of-range read
      w0 = wr_cnt; e0 = err_cnt;
      xfer(8'h84, 32'h00000000, 40, 1'b0, cap);
      cs_release();
      chk("t3_sdo_word", cap[31:0], 32'h12345678);
      chk("t3_no_wr", 32'(wr_cnt - w0), 32'd0);
      chk("t3_no_err", 32'(err_cnt - e0), 32'd0);
      xfer(8'hF0, 32'h00000000, 40, 1'b0, cap);
      cs_release();
      chk("t3_oor_read_err", 32'(err_cnt - e0), 32'd1);

      // 4: out-of-range write, then CFR2/CFR4 frames
      w0 = wr_cnt; e0 = err_cnt;
      full_write(7'h7F, 32'hDEADBEEF);
      chk("t4_oor_err", 32'(err_cnt - e0), 32'd1);
      chk("t4_oor_no_wr", 32'(wr_cnt - w0), 32'd0);
      pulse_update();
      rd_reg(7'h0F, v);     chk("t4_reg15_untouched", v, 32'd0);
      rd_reg(RAMP_LO, v);   chk("t4_ramp_lo_kept", v, 32'h12345678);
      rd_reg(RAMP_HI, v);   chk("t4_ramp_hi_committed", v, 32'hCAFEF00D);
      full_write(CFR2, 32'h00082900);
      pulse_update();
      full_write(CFR4, 32'h01052120);
      pulse_update();
      rd_reg(CFR2, v);      chk("t4_cfr2", v, 32'h00082900);
      rd_reg(CFR4, v);      chk("t4_cfr4", v, 32'h01052120);

      // 5: IO_Update rise coincides with write completion
      u0 = upd_cnt;
      xfer({1'b0, STEP_UP}, 32'h00000ABC, 40, 1'b1, cap);
      io_update = 1'b0;
      cs_release();
      chk("t5_upd_count", 32'(upd_cnt - u0), 32'd1);
      rd_reg(STEP_UP, v);   chk("t5_step_up", v, 32'h00000ABC);

      // 6: reset in the middle of a write
      xfer({1'b0, STEP_DN}, 32'h55AA55AA, 20, 1'b0, cap);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_strobes", {28'd0, sdo, wr_valid, update, error}, 32'd0);
      chk("t6_wr_addr", {25'd0, wr_addr}, 32'd0);
      chk("t6_wr_data", wr_data, 32'd0);
      chk("t6_rd_data", rd_data, 32'd0);
      e0 = err_cnt;
      cs_release();
      pulse_update();
      rd_reg(STEP_UP, v);   chk("t6_step_up_cleared", v, 32'd0);
      rd_reg(CFR2, v);      chk("t6_cfr2_cleared", v, 32'd0);
      w0 = wr_cnt;
      full_write(STEP_DN, 32'h87654321);
      chk("t6_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("t6_wr_addr_after", {25'd0, last_wr_addr}, 32'h7);
      chk("t6_wr_data_after", last_wr_data, 32'h87654321);
      chk("t6_no_err", 32'(err_cnt - e0), 32'd0);
      pulse_update();
      rd_reg(STEP_DN, v);   chk("t6_step_dn", v, 32'h87654321);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
